shift_register_sequencer: RTL and testbench
===========================================

Name: shift_register_sequencer

Overview:
- Command-driven controller for the 4-bit universal shift register (mode pins S1/S0, serial inputs, parallel load).
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right by N, shift left by N, or rotate right by N.
- Drives the register's mode and data pins for exactly the required number of clocks, then returns the register to hold and pulses done.
- Sits between a bus-side requester and the register instance; both share clk and clear.

Parameters:
WIDTH, 4, register width; width of cmd_data, reg_q and Parallel_In.
CNT_W, 3, width of the shift count; maximum count is 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
clear  input  1  asynchronous active-low reset.
cmd_valid  input  1  requester presents a command.
cmd_ready  output  1  sequencer can accept; a transfer occurs on any rising edge where cmd_valid and cmd_ready are both 1.
cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 rotate right.
cmd_count  input  CNT_W  number of shift steps; ignored for load.
cmd_data  input  WIDTH  parallel word for load.
cmd_fill  input  1  serial fill bit for shift left/right.
reg_q  input  WIDTH  current register contents, fed back for rotate.
S1  output  1  register mode MSB.
S0  output  1  register mode LSB.
shift_right  output  1  register serial input at the MSB end.
shift_left  output  1  register serial input at the LSB end.
Parallel_In  output  WIDTH  register parallel data.
busy  output  1  command in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- State machine: IDLE, RUN, DONE.
  - S1/S0 = 00 in IDLE and DONE.
  - In RUN, {S1,S0} = 11 for load, 01 for shift right and rotate right, 10 for shift left.
- Reset (clear=0, asynchronous):
  - state=IDLE; S1=S0=0; shift_right=shift_left=0; Parallel_In=0; busy=0; done=0; internal op/count/fill/data registers cleared.
  - cmd_ready=1 while in reset and in IDLE.
- Reset mid-operation: the command is aborted with no completion pulse, and S1/S0 go to 00 immediately.
- cmd_ready = 1 in IDLE and DONE, 0 in RUN.
- Accept (edge E0):
  - Latch op, count, data and fill.
  - Count 0 with a shift or rotate op goes straight to DONE: the register is untouched and done=1 in the cycle after E0.
  - Any other command goes to RUN, with busy=1.
- RUN, load:
  - One cycle; Parallel_In = latched data, S=11.
  - The register captures the word at E1; the sequencer enters DONE at E1.
- RUN, shift or rotate with count N:
  - The mode is held for N cycles and the register steps at E1..EN.
  - An internal counter, loaded with N at E0, decrements each RUN cycle; leave RUN at the edge where the counter equals 1.
- Serial pins:
  - Shift right: shift_right = latched fill. Shift left: shift_left = latched fill.
  - Rotate right: shift_right = reg_q[0], combinational, so the LSB wraps into the MSB at each step edge.
  - The unused serial pin is 0.
  - Parallel_In holds the latched data; it is don't-care outside load.
- DONE:
  - Lasts exactly one cycle with done=1, busy=0, S=00.
  - Go to IDLE, or to RUN (or straight back to DONE for count 0) if a new command is accepted at that edge. Back-to-back commands therefore lose one hold cycle.
- Command inputs need only be stable at the accept edge; they are ignored while cmd_ready=0.
- All outputs except cmd_ready and the rotate serial path are registered.

Test Plan:
- Reset, then load 4'b1010 -> S=11 for exactly 1 cycle; register = 1010; done pulses 1 cycle later; cmd_ready=0 only during RUN.
- After load 1010, shift right N=2 with fill=1 -> S=01 for 2 cycles; register = 1110; done 1 cycle; S returns to 00.
- After load 0001, shift left N=3 with fill=0 -> S=10 for 3 cycles; register = 1000.
- After load 0011, rotate right N=5 -> register = 1001; serial pin tracks reg_q[0] each cycle; N=7 from 0011 gives 0110.
- Shift with count 0 -> no S activity; done in the cycle after accept. Back-to-back: load then a shift issued in the DONE cycle -> accepted with no idle gap, one S=00 cycle between the two.
- Assert clear during the 2nd cycle of a shift right N=6 -> S, busy and done all 0 immediately; no done pulse; after release, the sequencer accepts a new load normally.

Source files
------------

// File: rtl/shift_register_sequencer.sv
// Command sequencer for a 4-bit universal shift register.
// Drives mode, serial and parallel pins for load/shift/rotate commands.
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
  output logic             S1,
  output logic             S0,
  output logic             shift_right,
  output logic             shift_left,
  output logic [WIDTH-1:0] Parallel_In,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       s_q, s_d;
  logic             sr_q, sr_d;
  logic             sl_q, sl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             unused_reg;

  assign unused_reg = ^reg_q[WIDTH-1:1];

  assign cmd_ready   = (state_q != RUN);
  assign accept      = cmd_valid && cmd_ready;
  assign S1          = s_q[1];
  assign S0          = s_q[0];
  assign shift_left  = sl_q;
  assign Parallel_In = data_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Rotate feeds the LSB straight back so it wraps on every step edge
  assign shift_right = (state_q == RUN && op_q == OP_ROR)
                     ? reg_q[0] : sr_q;

  // Next-state, latched command and registered pin values
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    s_d     = 2'b00;
    sr_d    = 1'b0;
    sl_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          s_d    = s_q;
          sr_d   = (op_q == OP_SHR) ? fill_q : 1'b0;
          sl_d   = (op_q == OP_SHL) ? fill_q : 1'b0;
          busy_d = 1'b1;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d   = cmd_op;
          cnt_d  = cmd_count;
          fill_d = cmd_fill;
          data_d = cmd_data;
          if (cmd_op != OP_LD && cmd_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            unique case (cmd_op)
              OP_LD: begin
                s_d   = 2'b11;
                cnt_d = CNT_W'(1);
              end
              OP_SHR: begin
                s_d  = 2'b01;
                sr_d = cmd_fill;
              end
              OP_SHL: begin
                s_d  = 2'b10;
                sl_d = cmd_fill;
              end
              OP_ROR: s_d = 2'b01;
              default: s_d = 2'b00;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; clear aborts any command at once
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
      s_q     <= 2'b00;
      sr_q    <= 1'b0;
      sl_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      s_q     <= s_d;
      sr_q    <= sr_d;
      sl_q    <= sl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Scoreboard bench for shift_register_sequencer.
// Includes a behavioural 4-bit universal shift register.
module tb_shift_register_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic [3:0] reg_q;
  logic       S1, S0;
  logic       shift_right, shift_left;
  logic [3:0] Parallel_In;
  logic       busy, done;

  always #5 clk = ~clk;

  shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .clear       (clear),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_data    (cmd_data),
    .cmd_fill    (cmd_fill),
    .reg_q       (reg_q),
    .S1          (S1),
    .S0          (S0),
    .shift_right (shift_right),
    .shift_left  (shift_left),
    .Parallel_In (Parallel_In),
    .busy        (busy),
    .done        (done)
  );

  // Universal shift register: 00 hold, 01 right, 10 left, 11 load
  always @(posedge clk or negedge clear) begin
    if (!clear) reg_q <= 4'b0000;
    else begin
      case ({S1, S0})
        2'b11:   reg_q <= Parallel_In;
        2'b01:   reg_q <= {shift_right, reg_q[3:1]};
        2'b10:   reg_q <= {reg_q[2:0], shift_left};
        default: reg_q <= reg_q;
      endcase
    end
  end

  typedef struct {
    logic [1:0] mode;
    int         cycles;
    logic [3:0] rq;
    logic       rot;
    logic       fill;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total = 0;
  int   active_cnt = 0;
  bit   allow_orphan = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: checks pins during RUN and the result at each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!clear) active_cnt = 0;
    else begin
      if ({S1, S0} != 2'b00) begin
        if (sb.size() == 0) begin
          if (!allow_orphan) chk("orphan_mode", {S1, S0}, 0);
        end else begin
          active_cnt++;
          chk("mode", {S1, S0}, sb[0].mode);
          chk("run_ready", cmd_ready, 0);
          chk("run_busy", busy, 1);
          chk("sr_pin", shift_right,
              sb[0].rot ? reg_q[0]
                        : (sb[0].mode == 2'b01 ? sb[0].fill : 1'b0));
          chk("sl_pin", shift_left,
              sb[0].mode == 2'b10 ? sb[0].fill : 1'b0);
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("orphan_done", done, 0);
        else begin
          e = sb.pop_front();
          chk("result", reg_q, e.rq);
          chk("steps", active_cnt, e.cycles);
          chk("done_mode", {S1, S0}, 0);
          chk("done_busy", busy, 0);
          chk("done_ready", cmd_ready, 1);
          active_cnt = 0;
        end
      end
    end
  end

  // Call at a negedge; returns 1 time unit after the accept edge
  task automatic issue(input logic [1:0] op, input logic [2:0] n,
                       input logic [3:0] d, input logic f,
                       input logic [1:0] mode, input int cyc,
                       input logic [3:0] rq, input bit push);
    exp_t e;
    int   w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = n;
    cmd_data  = d;
    cmd_fill  = f;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
    if (push) begin
      e.mode   = mode;
      e.cycles = cyc;
      e.rq     = rq;
      e.rot    = (op == 2'b11);
      e.fill   = f;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 3'd0;
    cmd_data  = 4'h0;
    cmd_fill  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int w;
    clear     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 3'd0;
    cmd_data  = 4'h0;
    cmd_fill  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mode", {S1, S0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pin", Parallel_In, 0);
    chk("rst_serial", {shift_right, shift_left}, 0);
    chk("rst_ready", cmd_ready, 1);
    clear = 1'b1;
    @(negedge clk);

    issue(2'b00, 3'd0, 4'b1010, 1'b0, 2'b11, 1, 4'b1010, 1);
    chk("ld_mode", {S1, S0}, 2'b11);
    chk("ld_ready", cmd_ready, 0);
    chk("ld_pin", Parallel_In, 4'b1010);
    drain();

    issue(2'b01, 3'd2, 4'h0, 1'b1, 2'b01, 2, 4'b1110, 1);
    drain();
    chk("idle_mode", {S1, S0}, 0);

    issue(2'b00, 3'd0, 4'b0001, 1'b0, 2'b11, 1, 4'b0001, 1);
    drain();
    issue(2'b10, 3'd3, 4'h0, 1'b0, 2'b10, 3, 4'b1000, 1);
    drain();

    issue(2'b00, 3'd0, 4'b0011, 1'b0, 2'b11, 1, 4'b0011, 1);
    drain();
    issue(2'b11, 3'd5, 4'h0, 1'b0, 2'b01, 5, 4'b1001, 1);
    drain();

    issue(2'b00, 3'd0, 4'b0011, 1'b0, 2'b11, 1, 4'b0011, 1);
    drain();
    issue(2'b11, 3'd7, 4'h0, 1'b0, 2'b01, 7, 4'b0110, 1);
    drain();

    issue(2'b01, 3'd0, 4'h0, 1'b1, 2'b00, 0, 4'b0110, 1);
    chk("cnt0_done", done, 1);
    chk("cnt0_mode", {S1, S0}, 0);
    chk("cnt0_busy", busy, 0);
    drain();

    issue(2'b00, 3'd0, 4'b1100, 1'b0, 2'b11, 1, 4'b1100, 1);
    w = 0;
    @(negedge clk);
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_done_seen", done, 1);
    issue(2'b10, 3'd1, 4'h0, 1'b1, 2'b10, 1, 4'b1001, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_mode", {S1, S0}, 2'b10);
    drain();

    allow_orphan = 1;
    issue(2'b01, 3'd6, 4'h0, 1'b1, 2'b01, 6, 4'h0, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("abort_mode", {S1, S0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    allow_orphan = 0;
    repeat (3) @(negedge clk);

    issue(2'b00, 3'd0, 4'b0110, 1'b0, 2'b11, 1, 4'b0110, 1);
    drain();
    issue(2'b11, 3'd1, 4'h0, 1'b0, 2'b01, 1, 4'b0011, 1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
